// File: rtl/sb_pkg.sv
// Shared store-buffer definitions for the drain path.
// Line count, index width, vector types and arbiter states.
package sb_pkg;

    localparam int SB_NO_OF_LINES = 8;
    localparam int SB_IDX_W       = $clog2(SB_NO_OF_LINES);

    typedef logic [SB_IDX_W-1:0]       sb_idx_t;
    typedef logic [SB_NO_OF_LINES-1:0] sb_linevec_t;

    typedef enum logic {
        SB_ARB_IDLE,
        SB_ARB_OFFER
    } sb_arb_state_e;

endpackage

// File: rtl/sb_first_set_enc.sv
// Lowest-set-bit encoder, any width.
// found is 0 and idx is 0 when the vector is empty.
module sb_first_set_enc
    import sb_pkg::*;
#(
    parameter int W     = SB_NO_OF_LINES,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_drain_arbiter.sv
// Registered drain-line selector for the store buffer.
// Fixed or round-robin pick, held under valid/ready, with flush.
module sb_drain_arbiter
    import sb_pkg::*;
#(
    parameter int N_LINES = SB_NO_OF_LINES,
    parameter bit RR_EN   = 1'b1,
    parameter int IDX_W   = $clog2(N_LINES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [N_LINES-1:0] req_i,
    output logic               sel_valid_o,
    output logic [IDX_W-1:0]   sel_idx_o,
    output logic [N_LINES-1:0] sel_onehot_o,
    input  logic               sel_ready_i,
    output logic [IDX_W-1:0]   ptr_o
);

    sb_arb_state_e      state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_LINES-1:0] onehot_q, onehot_d;

    logic               accept;
    logic [IDX_W-1:0]   idx_inc;
    logic [IDX_W-1:0]   ptr_eff;
    logic [N_LINES-1:0] cand;
    logic [N_LINES-1:0] mask;
    logic [N_LINES-1:0] masked;
    logic [IDX_W-1:0]   m_idx, a_idx;
    logic               m_found, a_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_LINES-1:0] pick_onehot;

    assign accept  = (state_q == SB_ARB_OFFER) && sel_ready_i;
    assign idx_inc = (idx_q == IDX_W'(N_LINES - 1)) ? '0 : idx_q + IDX_W'(1);

    // On accept the search already starts from the advanced pointer.
    assign ptr_eff = !RR_EN ? '0 : (accept ? idx_inc : ptr_q);

    // The line just granted is excluded from a back-to-back pick.
    assign cand = req_i & ~onehot_q;

    // Thermometer mask keeping lines at or above the pointer.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_LINES; i++) begin
            mask[i] = (i >= int'(ptr_eff));
        end
    end

    assign masked = cand & mask;

    sb_first_set_enc #(.W(N_LINES), .IDX_W(IDX_W)) u_enc_mask (
        .vec   (masked),
        .idx   (m_idx),
        .found (m_found)
    );

    sb_first_set_enc #(.W(N_LINES), .IDX_W(IDX_W)) u_enc_all (
        .vec   (cand),
        .idx   (a_idx),
        .found (a_found)
    );

    // Masked hit wins; otherwise wrap to the lowest candidate.
    assign pick_idx = (RR_EN && m_found) ? m_idx : a_idx;

    // One-hot form of the pick.
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < N_LINES; i++) begin
            pick_onehot[i] = (pick_idx == IDX_W'(i));
        end
    end

    // Next-state: flush beats accept, accept beats hold.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (flush_i) begin
            state_d  = SB_ARB_IDLE;
            ptr_d    = '0;
            idx_d    = '0;
            onehot_d = '0;
        end else begin
            unique case (state_q)
                SB_ARB_IDLE: begin
                    if (a_found) begin
                        state_d  = SB_ARB_OFFER;
                        idx_d    = pick_idx;
                        onehot_d = pick_onehot;
                    end
                end
                SB_ARB_OFFER: begin
                    if (sel_ready_i) begin
                        ptr_d = ptr_eff;
                        if (a_found) begin
                            idx_d    = pick_idx;
                            onehot_d = pick_onehot;
                        end else begin
                            state_d  = SB_ARB_IDLE;
                            idx_d    = '0;
                            onehot_d = '0;
                        end
                    end
                end
                default: state_d = SB_ARB_IDLE;
            endcase
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SB_ARB_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign sel_valid_o  = (state_q == SB_ARB_OFFER);
    assign sel_idx_o    = idx_q;
    assign sel_onehot_o = onehot_q;
    assign ptr_o        = ptr_q;

endmodule

// File: tb/tb_sb_drain_arbiter.sv
// Bench for sb_drain_arbiter: three configurations checked every
// cycle against a circular-search model, plus directed expectations.
module tb_sb_drain_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] req [3];
    logic       rdy [3];
    logic       fl  [3];
    logic       v   [3];
    logic [2:0] idx [3];
    logic [2:0] ptr [3];
    logic [7:0] oh  [3];
    logic [5:0] oh2;

    assign oh[2] = {2'b00, oh2};

    sb_drain_arbiter #(.N_LINES(8), .RR_EN(1'b1)) u_rr8 (
        .clk(clk), .rst(rst), .flush_i(fl[0]), .req_i(req[0]),
        .sel_valid_o(v[0]), .sel_idx_o(idx[0]), .sel_onehot_o(oh[0]),
        .sel_ready_i(rdy[0]), .ptr_o(ptr[0])
    );

    sb_drain_arbiter #(.N_LINES(8), .RR_EN(1'b0)) u_fx8 (
        .clk(clk), .rst(rst), .flush_i(fl[1]), .req_i(req[1]),
        .sel_valid_o(v[1]), .sel_idx_o(idx[1]), .sel_onehot_o(oh[1]),
        .sel_ready_i(rdy[1]), .ptr_o(ptr[1])
    );

    sb_drain_arbiter #(.N_LINES(6), .RR_EN(1'b1)) u_rr6 (
        .clk(clk), .rst(rst), .flush_i(fl[2]), .req_i(req[2][5:0]),
        .sel_valid_o(v[2]), .sel_idx_o(idx[2]), .sel_onehot_o(oh2),
        .sel_ready_i(rdy[2]), .ptr_o(ptr[2])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an offer plus a pointer; picks search circularly from ptr.
    int N  [3] = '{8, 8, 6};
    bit RR [3] = '{1'b1, 1'b0, 1'b1};
    bit mv [3];
    int mi [3];
    int mp [3];

    function automatic int pick(input int n, input logic [7:0] r, input int p);
        for (int j = 0; j < n; j++) begin
            if (r[(p + j) % n]) return (p + j) % n;
        end
        return -1;
    endfunction

    task automatic mstep(input int k, output bit nv, output int ni, output int np);
        logic [7:0] r;
        int c;
        nv = mv[k];
        ni = mi[k];
        np = mp[k];
        r  = req[k];
        if (fl[k]) begin
            nv = 1'b0;
            np = 0;
        end else if (!nv) begin
            c = pick(N[k], r, np);
            if (c >= 0) begin
                nv = 1'b1;
                ni = c;
            end
        end else if (rdy[k]) begin
            if (RR[k]) np = (ni + 1) % N[k];
            r[ni] = 1'b0;
            c = pick(N[k], r, np);
            if (c >= 0) ni = c;
            else nv = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            bit nv;
            int ni, np;
            if (rst) begin
                mv[k] <= 1'b0;
                mi[k] <= 0;
                mp[k] <= 0;
            end else begin
                mstep(k, nv, ni, np);
                mv[k] <= nv;
                mi[k] <= ni;
                mp[k] <= np;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m%0d valid", k), int'(v[k]), int'(mv[k]));
            chk($sformatf("m%0d ptr", k), int'(ptr[k]), RR[k] ? mp[k] : 0);
            chk($sformatf("m%0d onehot", k), int'(oh[k]), mv[k] ? (1 << mi[k]) : 0);
            if (mv[k]) chk($sformatf("m%0d idx", k), int'(idx[k]), mi[k]);
        end
    end

    task automatic lit(input int k, input string nm, input int ev, input int ei,
                       input int ep);
        chk({nm, " valid"}, int'(v[k]), ev);
        if (ev != 0) chk({nm, " idx"}, int'(idx[k]), ei);
        chk({nm, " ptr"}, int'(ptr[k]), ep);
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 8'h00;
            rdy[k] = 1'b0;
            fl[k]  = 1'b0;
        end
        #1 rst = 1'b1;

        // Reset and first-pick latency
        req[0] = 8'hA4;
        repeat (3) @(negedge clk);
        chk("t1 rst valid", int'(v[0]), 0);
        chk("t1 rst idx", int'(idx[0]), 0);
        chk("t1 rst onehot", int'(oh[0]), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t1 pre valid", int'(v[0]), 0);
        @(negedge clk);
        lit(0, "t1 offer", 1, 2, 0);
        chk("t1 onehot", int'(oh[0]), 8'h04);
        req[0] = 8'h00;
        rdy[0] = 1'b1;
        @(negedge clk);
        lit(0, "t1 drained", 0, 0, 3);
        rdy[0] = 1'b0;

        // Round-robin over all eight lines
        fl[0] = 1'b1;
        @(negedge clk);
        lit(0, "t2 flushed", 0, 0, 0);
        fl[0]  = 1'b0;
        req[0] = 8'hFF;
        rdy[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            lit(0, $sformatf("t2 g%0d", i), 1, i % 8, i % 8);
        end
        req[0] = 8'h00;
        @(negedge clk);
        lit(0, "t2 idle", 0, 0, 1);
        rdy[0] = 1'b0;

        // Stall with changing requests
        req[0] = 8'h08;
        @(negedge clk);
        lit(0, "t3 offer", 1, 3, 1);
        req[0] = 8'h00;
        @(negedge clk);
        lit(0, "t3 hold a", 1, 3, 1);
        req[0] = 8'h81;
        @(negedge clk);
        lit(0, "t3 hold b", 1, 3, 1);
        @(negedge clk);
        lit(0, "t3 hold c", 1, 3, 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        lit(0, "t3 next", 1, 7, 4);
        req[0] = 8'h00;
        @(negedge clk);
        lit(0, "t3 idle", 0, 0, 0);
        rdy[0] = 1'b0;

        // Fixed priority instance
        req[1] = 8'h90;
        @(negedge clk);
        lit(1, "t4 g0", 1, 4, 0);
        req[1] = 8'h00;
        rdy[1] = 1'b1;
        @(negedge clk);
        lit(1, "t4 idle", 0, 0, 0);
        req[1] = 8'h90;
        rdy[1] = 1'b0;
        @(negedge clk);
        lit(1, "t4 g1", 1, 4, 0);
        req[1] = 8'h80;
        rdy[1] = 1'b1;
        @(negedge clk);
        lit(1, "t4 lone", 1, 7, 0);
        req[1] = 8'h00;
        @(negedge clk);
        lit(1, "t4 end", 0, 0, 0);
        rdy[1] = 1'b0;

        // Flush beats accept
        req[0] = 8'h20;
        @(negedge clk);
        lit(0, "t5 offer", 1, 5, 0);
        req[0] = 8'h60;
        rdy[0] = 1'b1;
        fl[0]  = 1'b1;
        @(negedge clk);
        lit(0, "t5 flush", 0, 0, 0);
        fl[0]  = 1'b0;
        rdy[0] = 1'b0;
        @(negedge clk);
        lit(0, "t5 repick", 1, 5, 0);
        req[0] = 8'h00;
        rdy[0] = 1'b1;
        @(negedge clk);
        lit(0, "t5 idle", 0, 0, 6);
        rdy[0] = 1'b0;

        // Six-line round-robin wrap
        req[2] = 8'h21;
        rdy[2] = 1'b1;
        @(negedge clk);
        lit(2, "t6 g0", 1, 0, 0);
        @(negedge clk);
        lit(2, "t6 g1", 1, 5, 1);
        @(negedge clk);
        lit(2, "t6 g2", 1, 0, 0);
        @(negedge clk);
        lit(2, "t6 g3", 1, 5, 1);
        req[2] = 8'h00;
        @(negedge clk);
        lit(2, "t6 idle", 0, 0, 0);
        rdy[2] = 1'b0;

        // Asynchronous reset in the middle of an offer
        req[0] = 8'hFF;
        @(negedge clk);
        lit(0, "t7 offer", 1, 6, 6);
        #2 rst = 1'b1;
        #1;
        chk("t7 async valid", int'(v[0]), 0);
        chk("t7 async ptr", int'(ptr[0]), 0);
        chk("t7 async onehot", int'(oh[0]), 0);
        @(negedge clk);
        req[0] = 8'h00;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sb_drain_arbiter.md
Name: sb_drain_arbiter

Overview:
- Registered, parametrised line selector for the store buffer drain path.
- Picks one pending store-buffer line per grant, in fixed lowest-index order or round-robin order.
- Holds the chosen index stable under a valid/ready handshake to the cache write port.
- Replaces the purely combinational 8-line encoders with a depth-generic block that has fairness state, back-to-back issue and flush.

Parameters:
- N_LINES, default SB_NO_OF_LINES (8): number of request lines; legal range 2..64, need not be a power of two.
- RR_EN, default 1: 1 selects round-robin order, 0 selects fixed lowest-index-first order.
- IDX_W, default $clog2(N_LINES): width of the index; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort: drop the current offer and reset the fairness pointer.
- req_i  in  N_LINES  one bit per line; 1 means the line holds data waiting to drain.
- sel_valid_o  out  1  an offer is present.
- sel_idx_o  out  IDX_W  index of the offered line.
- sel_onehot_o  out  N_LINES  one-hot form of sel_idx_o; all zero when sel_valid_o=0.
- sel_ready_i  in  1  consumer accepts the offer this cycle.
- ptr_o  out  IDX_W  current round-robin pointer, for debug and coverage; constant 0 when RR_EN=0.

Behaviour:
- Reset: rst asserted, asynchronously or mid-operation, forces the following within the same edge-free interval:
  - state=IDLE;
  - sel_valid_o=0, sel_idx_o=0, sel_onehot_o=0;
  - ptr=0.
  - Any pending offer is lost.
- State machine has two states, IDLE and OFFER.
- Candidate pick, computed combinationally from req_i each cycle:
  - RR_EN=0: lowest set bit of req_i.
  - RR_EN=1: lowest set bit at or above ptr (masked vector req_i & ~((1<<ptr)-1)). If that vector is empty, use the lowest set bit of the unmasked req_i, so the search wraps. ptr itself is eligible.
- IDLE:
  - If |req_i is 1 and flush_i is 0, register the pick into sel_idx_o and sel_onehot_o, and go to OFFER.
  - Latency is 1 cycle: a request at edge t gives sel_valid_o=1 after edge t+1.
- OFFER:
  - sel_valid_o=1. sel_idx_o and sel_onehot_o stay frozen until the offer is accepted or flushed, whatever req_i does, including deassertion of the offered bit.
- Accept happens on a clock edge where sel_valid_o=1 and sel_ready_i=1:
  - RR_EN=1: ptr <= sel_idx_o+1, wrapping to 0 when sel_idx_o=N_LINES-1 (modulo N_LINES, not 2^IDX_W).
  - Back-to-back: the next pick is computed from req_i & ~sel_onehot_o, with the pointer already advanced.
  - If that vector is non-zero, load the new pick and stay in OFFER; sel_valid_o stays 1, giving one grant per cycle.
  - Otherwise go to IDLE.
- Ready while idle: sel_ready_i is ignored when sel_valid_o=0.
- Flush: flush_i=1 goes to IDLE, sets sel_valid_o=0 and ptr=0 on the next edge. Flush has priority over accept and over a new pick. No grant is counted on a flush cycle, even if sel_ready_i=1.
- Invariants:
  - sel_onehot_o == (sel_valid_o ? 1<<sel_idx_o : 0).
  - sel_idx_o < N_LINES at all times.
- X-safety: req_i bits at or above N_LINES do not exist. There are no latches; all state sits in one always_ff with async rst.

Decomposition:
- Shared package sb_pkg (sb_defs) holds:
  - SB_NO_OF_LINES;
  - SB_IDX_W = $clog2(SB_NO_OF_LINES);
  - typedef sb_idx_t (logic [SB_IDX_W-1:0]);
  - typedef sb_linevec_t (logic [SB_NO_OF_LINES-1:0]);
  - enum sb_arb_state_e {SB_ARB_IDLE, SB_ARB_OFFER}.
- One sub-module, sb_first_set_enc: a combinational, parametrised lowest-set-bit encoder with outputs idx and found.
  - Instantiated twice, once on the masked vector and once on the unmasked vector.
  - The RR_EN=0 path uses only the unmasked instance.

Test Plan (N_LINES=8 unless noted):
1. Reset/latency: hold rst with req_i=0xA4, then release -> sel_valid_o=0 during reset; one cycle after release sel_valid_o=1, sel_idx_o=2, sel_onehot_o=0x04, ptr_o=0.
2. Round-robin fairness: RR_EN=1, req_i=0xFF, sel_ready_i=1 continuously -> grants 0,1,2,...,7,0 on consecutive cycles, with no bubble; ptr_o wraps 7->0.
3. Stall/hold: offer idx=3, sel_ready_i=0 for 4 cycles while req_i changes 0x08->0x00->0x81 -> sel_idx_o stays 3 throughout; on accept ptr_o=4 and the next grant is 7.
4. Fixed priority: RR_EN=0, req_i=0x90, accept idx 4, then req_i=0x90 again -> grants 4,4; ptr_o=0 throughout; a lone request 0x80 yields 7.
5. Flush precedence: during an offer of idx=5 with sel_ready_i=1, assert flush_i -> next cycle sel_valid_o=0, ptr_o=0, no grant counted; with req_i=0x60 the following pick is 5 from ptr=0.
6. Non-power-of-two: N_LINES=6, RR_EN=1, req_i=0x21, continuous ready -> grants 0,5,0,5; the pointer after 5 is 0, never 6 or 7.
